// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared definitions for the multicycle CPU sequencer: state encoding, the decoded
// instruction classes and the class priority used when several class lines are high.
package cpu_cycle_sequencer_pkg;

  localparam int LAT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE     = 2'd0,
    CLS_LOAD     = 2'd1,
    CLS_STORE    = 2'd2,
    CLS_REGWRITE = 2'd3
  } cls_t;

  // Halt is resolved before this; among the rest load wins over store over regwrite.
  function automatic cls_t classify(input logic load, input logic store, input logic regwrite);
    if (load) return CLS_LOAD;
    if (store) return CLS_STORE;
    if (regwrite) return CLS_REGWRITE;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_latency_counter.sv
// Down-counter that paces the ROM and RAM read waits; last_cycle flags the final wait cycle.
module cpu_cycle_sequencer_latency_counter
  import cpu_cycle_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_value,
  output logic             last_cycle,
  output logic             last_cycle_next
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The look-ahead lets the sequencer register strobes that line up with the final wait cycle.
  assign last_cycle      = (cnt_q == '0);
  assign last_cycle_next = (cnt_d == '0);

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Multicycle sequencer: paces fetch/decode/execute/memory/writeback with registered strobes,
// run/step/halt control and debug counters.
module cpu_cycle_sequencer
  import cpu_cycle_sequencer_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int RAM_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             cls_load,
  input  logic             cls_store,
  input  logic             cls_regwrite,
  input  logic             cls_halt,
  output logic             ir_load,
  output logic             pc_update,
  output logic             reg_write_en,
  output logic             ram_rden,
  output logic             ram_wren,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [LAT_W-1:0] ROM_LOAD = LAT_W'(ROM_LATENCY - 1);
  localparam logic [LAT_W-1:0] RAM_LOAD = LAT_W'(RAM_LATENCY - 1);

  state_t           state_q;
  state_t           state_d;
  state_t           retire_state;
  cls_t             cls_q;
  cls_t             cls_d;
  logic             step_q;
  logic             step_rise;
  logic             lat_load;
  logic [LAT_W-1:0] lat_value;
  logic             lat_last;
  logic             lat_last_next;
  logic             ir_load_d;
  logic             pc_update_d;
  logic             reg_write_en_d;
  logic             ram_rden_d;
  logic             ram_wren_d;

  assign step_rise    = step & ~step_q;
  assign retire_state = run ? S_FETCH : S_IDLE;
  assign cls_d        = (state_q == S_DECODE) ? classify(cls_load, cls_store, cls_regwrite) : cls_q;

  cpu_cycle_sequencer_latency_counter u_latency (
    .clk             (clk),
    .reset           (reset),
    .load            (lat_load),
    .load_value      (lat_value),
    .last_cycle      (lat_last),
    .last_cycle_next (lat_last_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run || step_rise) state_d = S_FETCH;
      S_FETCH:  state_d = S_FWAIT;
      S_FWAIT:  if (lat_last) state_d = S_DECODE;
      S_DECODE: state_d = cls_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_REGWRITE:        state_d = S_WB;
          default:             state_d = retire_state;
        endcase
      end
      S_MEM: begin
        if (cls_q == CLS_STORE) begin
          state_d = retire_state;
        end else if (lat_last) begin
          state_d = S_WB;
        end
      end
      S_WB:     state_d = retire_state;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // The wait counter is reloaded on entry to FWAIT (ROM) and MEM (RAM read).
  always_comb begin
    lat_load  = 1'b0;
    lat_value = ROM_LOAD;
    if (state_d == S_FWAIT && state_q != S_FWAIT) begin
      lat_load = 1'b1;
    end else if (state_d == S_MEM && state_q != S_MEM) begin
      lat_load  = 1'b1;
      lat_value = RAM_LOAD;
    end
  end

  // Strobes are decoded from the state being entered so the registered copies align with it.
  always_comb begin
    ir_load_d      = (state_d == S_FWAIT) && lat_last_next;
    pc_update_d    = 1'b0;
    reg_write_en_d = 1'b0;
    ram_rden_d     = 1'b0;
    ram_wren_d     = 1'b0;
    case (state_d)
      S_EXEC: pc_update_d = (cls_d == CLS_NONE);
      S_MEM: begin
        if (cls_d == CLS_STORE) begin
          ram_wren_d  = 1'b1;
          pc_update_d = 1'b1;
        end else begin
          ram_rden_d = 1'b1;
        end
      end
      S_WB: begin
        reg_write_en_d = 1'b1;
        pc_update_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cls_q        <= CLS_NONE;
      step_q       <= 1'b0;
      ir_load      <= 1'b0;
      pc_update    <= 1'b0;
      reg_write_en <= 1'b0;
      ram_rden     <= 1'b0;
      ram_wren     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      step_q       <= step;
      ir_load      <= ir_load_d;
      pc_update    <= pc_update_d;
      reg_write_en <= reg_write_en_d;
      ram_rden     <= ram_rden_d;
      ram_wren     <= ram_wren_d;
    end
  end

  // instr_retired tracks the strobe register so it already includes a visible pc_update.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instr_retired <= '0;
    end else begin
      if (busy) cycle_count <= cycle_count + CNT_W'(1);
      if (pc_update_d) instr_retired <= instr_retired + CNT_W'(1);
    end
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Bench for cpu_cycle_sequencer: per-instruction cycle schedules built from the timing rules.
module tb_cpu_cycle_sequencer;

  localparam logic [2:0] K_NONE = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_ALU = 3'd3, K_HALT = 3'd4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_FWAIT = 3'd2, ST_DECODE = 3'd3;
  localparam logic [2:0] ST_EXEC = 3'd4, ST_MEM = 3'd5, ST_WB = 3'd6, ST_HALT = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic ir, pc, rw, rd, wr, bz, hl;
  } obs_t;

  typedef struct packed {
    logic [2:0] kind;
    logic run_drv;
    logic step_drv;
    obs_t o;
  } plan_t;

  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0, step = 1'b0;
  logic cls_load = 1'b0, cls_store = 1'b0, cls_regwrite = 1'b0, cls_halt = 1'b0;
  logic ir_load, pc_update, reg_write_en, ram_rden, ram_wren, busy, halted;
  logic [2:0] state;
  logic [3:0] cycle_count, instr_retired;

  logic run2 = 1'b0;
  logic ir_load2, pc_update2, reg_write_en2, ram_rden2, ram_wren2, busy2, halted2;
  logic [2:0] state2;
  logic [3:0] cycle_count2, instr_retired2;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] cyc_m, ret_m;
  logic drv_run, drv_step;
  plan_t exp_q[$];

  always #5 clk = ~clk;

  cpu_cycle_sequencer #(.ROM_LATENCY(1), .RAM_LATENCY(3), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .cls_load(cls_load), .cls_store(cls_store), .cls_regwrite(cls_regwrite), .cls_halt(cls_halt),
    .ir_load(ir_load), .pc_update(pc_update), .reg_write_en(reg_write_en),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .busy(busy), .halted(halted), .state(state),
    .cycle_count(cycle_count), .instr_retired(instr_retired)
  );

  cpu_cycle_sequencer #(.ROM_LATENCY(3), .RAM_LATENCY(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .run(run2), .step(1'b0),
    .cls_load(1'b1), .cls_store(1'b0), .cls_regwrite(1'b0), .cls_halt(1'b0),
    .ir_load(ir_load2), .pc_update(pc_update2), .reg_write_en(reg_write_en2),
    .ram_rden(ram_rden2), .ram_wren(ram_wren2), .busy(busy2), .halted(halted2), .state(state2),
    .cycle_count(cycle_count2), .instr_retired(instr_retired2)
  );

  function automatic obs_t mk(input logic [2:0] st, input logic ir, input logic pc,
                              input logic rw, input logic rd, input logic wr);
    obs_t o;
    o.st = st; o.ir = ir; o.pc = pc; o.rw = rw; o.rd = rd; o.wr = wr;
    o.bz = (st != ST_IDLE) && (st != ST_HALT);
    o.hl = (st == ST_HALT);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.ir = ir_load; o.pc = pc_update; o.rw = reg_write_en;
    o.rd = ram_rden; o.wr = ram_wren; o.bz = busy; o.hl = halted;
    return o;
  endfunction

  function automatic obs_t observe2();
    obs_t o;
    o.st = state2; o.ir = ir_load2; o.pc = pc_update2; o.rw = reg_write_en2;
    o.rd = ram_rden2; o.wr = ram_wren2; o.bz = busy2; o.hl = halted2;
    return o;
  endfunction

  task automatic push(input logic [2:0] kind, input obs_t o);
    plan_t p;
    p.kind = kind; p.run_drv = drv_run; p.step_drv = drv_step; p.o = o;
    exp_q.push_back(p);
  endtask

  // Expected cycle-by-cycle schedule of one instruction, from FETCH to its retire cycle.
  task automatic push_instr(input logic [2:0] kind, input int rom, input int ram);
    push(kind, mk(ST_FETCH, 0, 0, 0, 0, 0));
    for (int i = 0; i < rom; i++) push(kind, mk(ST_FWAIT, i == rom - 1, 0, 0, 0, 0));
    push(kind, mk(ST_DECODE, 0, 0, 0, 0, 0));
    if (kind == K_HALT) begin
      push(kind, mk(ST_HALT, 0, 0, 0, 0, 0));
    end else begin
      push(kind, mk(ST_EXEC, 0, kind == K_NONE, 0, 0, 0));
      if (kind == K_LOAD) begin
        for (int i = 0; i < ram; i++) push(kind, mk(ST_MEM, 0, 0, 0, 1, 0));
        push(kind, mk(ST_WB, 0, 1, 1, 0, 0));
      end else if (kind == K_STORE) begin
        push(kind, mk(ST_MEM, 0, 1, 0, 0, 1));
      end else if (kind == K_ALU) begin
        push(kind, mk(ST_WB, 0, 1, 1, 0, 0));
      end
    end
  endtask

  // Class lines carry the planned class only in DECODE; elsewhere they are noise.
  task automatic tick(input plan_t p);
    if (p.o.st == ST_DECODE) begin
      cls_halt = (p.kind == K_HALT);
      {cls_load, cls_store, cls_regwrite} = 3'($urandom);
      if (p.kind == K_LOAD) cls_load = 1'b1;
      else if (p.kind == K_STORE) begin cls_load = 1'b0; cls_store = 1'b1; end
      else if (p.kind == K_ALU) {cls_load, cls_store, cls_regwrite} = 3'b001;
      else if (p.kind == K_NONE) {cls_load, cls_store, cls_regwrite} = 3'b000;
    end else begin
      {cls_halt, cls_load, cls_store, cls_regwrite} = 4'($urandom);
    end
    if (p.o.bz) cyc_m = cyc_m + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; run2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (observe() !== mk(ST_IDLE, 0, 0, 0, 0, 0) || observe2() !== mk(ST_IDLE, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_outputs: got %b / %b, required all idle", observe(), observe2());
    end
    n_checks++;
    if (cycle_count !== 4'd0 || instr_retired !== 4'd0 || cycle_count2 !== 4'd0) begin
      n_fail++; $display("FAIL reset_counters: cycles=%0d retired=%0d, required 0 0", cycle_count, instr_retired);
    end
    reset = 1'b0;
    cyc_m = 4'd0; ret_m = 4'd0; drv_run = 1'b1; drv_step = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_alu();
    plan_t p;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_ALU, 1, 3);
    push_instr(K_ALU, 1, 3);
    exp_q[exp_q.size() - 1].run_drv = 1'b0;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      if (p.o.pc) ret_m = ret_m + 4'd1;
      n_checks++;
      if (observe() !== p.o) begin
        n_fail++; $display("FAIL alu_trace: outputs %b, required %b", observe(), p.o);
      end
      n_checks++;
      if (instr_retired !== ret_m || cycle_count !== cyc_m) begin
        n_fail++; $display("FAIL alu_counters: retired=%0d cycles=%0d, required %0d %0d", instr_retired, cycle_count, ret_m, cyc_m);
      end
      run = p.run_drv; step = p.step_drv;
      tick(p);
    end
  endtask

  task automatic test_load_latency();
    plan_t p;
    int rden_cycles = 0;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_LOAD, 1, 3);
    exp_q[exp_q.size() - 1].run_drv = 1'b0;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      if (p.o.pc) ret_m = ret_m + 4'd1;
      if (ram_rden === 1'b1) rden_cycles++;
      n_checks++;
      if (observe() !== p.o) begin
        n_fail++; $display("FAIL load_trace: outputs %b, required %b", observe(), p.o);
      end
      n_checks++;
      if (instr_retired !== ret_m || cycle_count !== cyc_m) begin
        n_fail++; $display("FAIL load_counters: retired=%0d cycles=%0d, required %0d %0d", instr_retired, cycle_count, ret_m, cyc_m);
      end
      run = p.run_drv; step = p.step_drv;
      tick(p);
    end
    n_checks++;
    if (rden_cycles != 3 || cycle_count !== 4'd8) begin
      n_fail++; $display("FAIL load_rden_len: rden cycles=%0d busy cycles=%0d, required 3 8", rden_cycles, cycle_count);
    end
  endtask

  task automatic test_back_to_back();
    plan_t p;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_STORE, 1, 3);
    push_instr(K_NONE, 1, 3);
    exp_q[exp_q.size() - 1].run_drv = 1'b0;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      if (p.o.pc) ret_m = ret_m + 4'd1;
      n_checks++;
      if (observe() !== p.o) begin
        n_fail++; $display("FAIL b2b_trace: outputs %b, required %b", observe(), p.o);
      end
      n_checks++;
      if (instr_retired !== ret_m || cycle_count !== cyc_m) begin
        n_fail++; $display("FAIL b2b_counters: retired=%0d cycles=%0d, required %0d %0d", instr_retired, cycle_count, ret_m, cyc_m);
      end
      run = p.run_drv; step = p.step_drv;
      tick(p);
    end
    n_checks++;
    if (instr_retired !== 4'd2 || cycle_count !== 4'd9) begin
      n_fail++; $display("FAIL b2b_totals: retired=%0d cycles=%0d, required 2 9", instr_retired, cycle_count);
    end
  endtask

  task automatic test_step();
    plan_t p;
    drv_run = 1'b0; drv_step = 1'b1;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_ALU, 1, 3);
    repeat (14) push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    drv_step = 1'b0;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    drv_step = 1'b1;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_NONE, 1, 3);
    repeat (3) push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      if (p.o.pc) ret_m = ret_m + 4'd1;
      n_checks++;
      if (observe() !== p.o) begin
        n_fail++; $display("FAIL step_trace: outputs %b, required %b", observe(), p.o);
      end
      n_checks++;
      if (instr_retired !== ret_m || cycle_count !== cyc_m) begin
        n_fail++; $display("FAIL step_counters: retired=%0d cycles=%0d, required %0d %0d", instr_retired, cycle_count, ret_m, cyc_m);
      end
      run = p.run_drv; step = p.step_drv;
      tick(p);
    end
    n_checks++;
    if (instr_retired !== 4'd2) begin
      n_fail++; $display("FAIL step_total: retired=%0d, required 2", instr_retired);
    end
    step = 1'b0;
  endtask

  task automatic test_halt();
    plan_t p;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_HALT, 1, 3);
    repeat (6) push(K_NONE, mk(ST_HALT, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      if (p.o.pc) ret_m = ret_m + 4'd1;
      n_checks++;
      if (observe() !== p.o) begin
        n_fail++; $display("FAIL halt_trace: outputs %b, required %b", observe(), p.o);
      end
      n_checks++;
      if (instr_retired !== ret_m || cycle_count !== cyc_m) begin
        n_fail++; $display("FAIL halt_counters: retired=%0d cycles=%0d, required %0d %0d", instr_retired, cycle_count, ret_m, cyc_m);
      end
      if (p.o.st == ST_HALT) begin run = 1'($urandom); step = 1'($urandom); end
      else begin run = p.run_drv; step = p.step_drv; end
      tick(p);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (observe() !== mk(ST_IDLE, 0, 0, 0, 0, 0) || cycle_count !== 4'd0 || instr_retired !== 4'd0) begin
      n_fail++; $display("FAIL halt_reset: outputs %b cycles=%0d retired=%0d, required idle 0 0", observe(), cycle_count, instr_retired);
    end
    reset = 1'b0; run = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    plan_t p;
    int mem_seen = 0;
    logic aborted = 1'b0;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_LOAD, 1, 3);
    while (exp_q.size() > 0 && !aborted) begin
      p = exp_q.pop_front();
      if (p.o.pc) ret_m = ret_m + 4'd1;
      n_checks++;
      if (observe() !== p.o) begin
        n_fail++; $display("FAIL midreset_trace: outputs %b, required %b", observe(), p.o);
      end
      run = p.run_drv; step = p.step_drv;
      if (p.o.st == ST_MEM) mem_seen++;
      if (mem_seen == 2) begin
        aborted = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (observe() !== mk(ST_IDLE, 0, 0, 0, 0, 0) || cycle_count !== 4'd0) begin
          n_fail++; $display("FAIL midreset_abort: outputs %b cycles=%0d, required idle 0", observe(), cycle_count);
        end
        reset = 1'b0; run = 1'b0;
        exp_q.delete();
      end else begin
        tick(p);
      end
    end
  endtask

  task automatic test_rom_latency();
    plan_t p;
    run2 = 1'b1;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_instr(K_LOAD, 3, 2);
    push_instr(K_LOAD, 3, 2);
    exp_q[exp_q.size() - 1].run_drv = 1'b0;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      if (p.o.pc) ret_m = ret_m + 4'd1;
      n_checks++;
      if (observe2() !== p.o) begin
        n_fail++; $display("FAIL rom_trace: outputs %b, required %b", observe2(), p.o);
      end
      n_checks++;
      if (instr_retired2 !== ret_m || cycle_count2 !== cyc_m) begin
        n_fail++; $display("FAIL rom_counters: retired=%0d cycles=%0d, required %0d %0d", instr_retired2, cycle_count2, ret_m, cyc_m);
      end
      run2 = p.run_drv;
      tick(p);
    end
  endtask

  // Random class mix; run is randomised mid-instruction and chosen freshly at each retire.
  task automatic test_random();
    plan_t p;
    logic rr;
    int idle_n;
    push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
    for (int n = 0; n < 30; n++) begin
      push_instr(3'($urandom_range(0, 3)), 1, 3);
      rr = ($urandom_range(0, 3) != 0);
      exp_q[exp_q.size() - 1].run_drv = rr;
      if (!rr) begin
        idle_n = $urandom_range(1, 3);
        for (int k = 0; k < idle_n; k++) begin
          drv_run = (k == idle_n - 1);
          push(K_NONE, mk(ST_IDLE, 0, 0, 0, 0, 0));
        end
        drv_run = 1'b1;
      end
      while (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        if (p.o.pc) ret_m = ret_m + 4'd1;
        n_checks++;
        if (observe() !== p.o) begin
          n_fail++; $display("FAIL random_trace: instr %0d outputs %b, required %b", n, observe(), p.o);
        end
        n_checks++;
        if (instr_retired !== ret_m || cycle_count !== cyc_m) begin
          n_fail++; $display("FAIL random_counters: retired=%0d cycles=%0d, required %0d %0d", instr_retired, cycle_count, ret_m, cyc_m);
        end
        if (p.o.pc || p.o.st == ST_IDLE) run = p.run_drv;
        else run = 1'($urandom);
        tick(p);
      end
    end
    run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_reset();
    test_load_latency();
    test_reset();
    test_back_to_back();
    test_reset();
    test_step();
    test_reset();
    test_halt();
    test_reset();
    test_reset_mid_load();
    test_reset();
    test_rom_latency();
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
